// File: rtl/keypad_encoder.sv
// ---------------------------------------------------------------------------
// keypad_encoder
//   Front end of the microwave timer-entry path. Synchronises and debounces the
//   ten raw digit buttons, encodes the accepted key to BCD and emits a one-cycle
//   active-low load strobe per physical key press.
//
// Ports
//   clock_i    : single clock, rising edge
//   clear_i    : asynchronous active-high reset
//   keypad_i   : raw buttons, bit i = digit i pressed (async, bouncy)
//   enablen_i  : active-low enable; 1 = keypad ignored
//   data_o     : BCD of last accepted digit, held until the next accept
//   loadn_o    : active-low one-cycle strobe, coincident with new data
//   busy_o     : 1 whenever the FSM is not idle
// ---------------------------------------------------------------------------
module keypad_encoder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic        clock_i,
    input  logic        clear_i,
    input  logic [9:0]  keypad_i,
    input  logic        enablen_i,
    output logic [3:0]  data_o,
    output logic        loadn_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DEB_PRESS   = 2'd1,
        LOAD        = 2'd2,
        DEB_RELEASE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        cand_q, cand_d;
    logic [9:0]        meta_q, ks_q;
    logic [3:0]        data_q, data_d;
    logic              loadn_q, loadn_d;
    logic              busy_q, busy_d;

    logic              ks_single;
    logic [3:0]        ks_idx;
    logic [9:0]        cand_mask;
    logic [CNT_W-1:0]  cnt_inc;

    // Two-flop synchroniser; the FSM only ever looks at ks_q.
    always_ff @(posedge clock_i or posedge clear_i) begin
        if (clear_i) begin
            meta_q <= '0;
            ks_q   <= '0;
        end else begin
            meta_q <= keypad_i;
            ks_q   <= meta_q;
        end
    end

    // Exactly-one-key detect and its index (0..9, so always valid BCD).
    always_comb begin
        ks_idx    = 4'd0;
        ks_single = ($countones(ks_q) == 1);
        for (int i = 0; i < 10; i++) begin
            if (ks_q[i]) ks_idx = 4'(i);
        end
    end

    assign cand_mask = 10'd1 << cand_q;
    // Saturating increment: a stuck counter is harmless, a wrapped one is not.
    assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        data_d  = data_q;
        loadn_d = 1'b1;
        case (state_q)
            IDLE: begin
                if (!enablen_i && ks_single) begin
                    cand_d  = ks_idx;
                    cnt_d   = CNT_W'(1);
                    state_d = DEB_PRESS;
                end
            end
            DEB_PRESS: begin
                if (!enablen_i && ks_q == cand_mask) begin
                    if (cnt_q == CNT_LAST) begin
                        // Registered outputs: data and strobe change on LOAD entry.
                        state_d = LOAD;
                        data_d  = cand_q;
                        loadn_d = 1'b0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                // Always completes regardless of enablen.
                state_d = DEB_RELEASE;
                cnt_d   = '0;
            end
            DEB_RELEASE: begin
                if (ks_q != '0) begin
                    // Held key never repeats; restart the release window.
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock_i or posedge clear_i) begin
        if (clear_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cand_q  <= '0;
            data_q  <= 4'd0;
            loadn_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            data_q  <= data_d;
            loadn_q <= loadn_d;
            busy_q  <= busy_d;
        end
    end

    assign data_o  = data_q;
    assign loadn_o = loadn_q;
    assign busy_o  = busy_q;

endmodule
